expande_chave_inversa: RTL and testbench
========================================

Name: expande_chave_inversa

Overview:
- Sequential AES-128 key schedule for the decryption path. Accepts the 128-bit cipher key, runs the forward schedule internally to reach round key K10, then streams the round keys in reverse order (K10, K9, … K0) to the inverse-cipher datapath.
- Delivers one key per accepted handshake and regenerates each earlier key on the fly with the inverse schedule step.
- Complements the combinational forward expander: no 1280-bit storage, one 128-bit working register.

Parameters:
- NUM_RODADAS, 10, number of AES rounds; fixed at 10 for AES-128, kept as a parameter for the counter width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- chave  in  128  cipher key, row-major byte layout: row r (0..3), column c (0..3) at bits [32r+8c+7 : 32r+8c]; sampled only when inicio is accepted.
- inicio  in  1  start pulse; accepted only in OCIOSO.
- ocupado  out  1  high from the cycle after inicio is accepted until the final handshake completes.
- chave_rodada  out  128  current round key, same layout as chave.
- rodada_idx  out  4  round index of chave_rodada (10 down to 0).
- valido  out  1  chave_rodada/rodada_idx are valid.
- pronto  in  1  consumer ready; the transfer occurs when valido && pronto.

Behaviour:
- Reset values: state=OCIOSO; ocupado=0, valido=0, chave_rodada=0, rodada_idx=0, internal counter=0. Reset has priority over all activity, including mid-expansion and mid-delivery; any transfer in progress is abandoned.
- Word g (existing funcaoG): input is column 3 with byte r = row r; applies RotWord, SubWord and Rcon[rodada]; Rcon for rodada 0..9 is 01,02,04,08,10,20,40,80,1b,36.
- Forward step, K(n-1) to K(n), per row r:
  - col0 = K(n-1).col0 ^ g(K(n-1).col3, n-1)
  - colc = colc-1(new) ^ K(n-1).colc, for c = 1..3
- Inverse step, K(n) to K(n-1):
  - colc(old) = K(n).colc ^ K(n).colc-1, for c = 3,2,1
  - col0(old) = K(n).col0 ^ g(col3(old), n-1)
- One funcaoG instance is shared between the two steps through a mux on the word and rodada inputs.
- OCIOSO:
  - inicio=1: latch chave into the working register, set contador=0, go to EXPANDE, set ocupado=1.
  - inicio=0: hold; valido=0.
- EXPANDE:
  - Each cycle applies one forward step and increments contador.
  - On the step that produces K10 (contador 9 to 10): go to ENTREGA, set valido=1, rodada_idx=10.
  - valido first rises exactly 10 cycles after the edge that accepted inicio.
  - inicio is ignored.
- ENTREGA:
  - chave_rodada and rodada_idx stay stable while valido && !pronto (no change under backpressure).
  - On valido && pronto with rodada_idx>0: the register takes the inverse step and rodada_idx decrements. valido stays high, so full-rate streaming gives one key per cycle.
  - On valido && pronto with rodada_idx==0: go to OCIOSO, valido=0, ocupado=0. chave_rodada keeps the K0 value.
  - inicio is ignored.
- inicio asserted in the same cycle as the final handshake is ignored; a new start needs a cycle in OCIOSO.
- Once K0 is delivered it equals the original chave bit-for-bit.
- Total keys per start: 11.

Decomposition:
- Shared package (pacote_aes) holds:
  - NUM_RODADAS and the Rcon constant table.
  - The S-box constant table.
  - The 128-bit key type and 32-bit word type.
  - The state enum (OCIOSO, EXPANDE, ENTREGA).
- Sub-module: reuse funcaoG unchanged, one instance. Do not create a separate inverse-g module.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c (columns, packed per layout), pronto=1 → valido 10 cycles after inicio; first key rodada_idx=10, d014f9a8 c9ee2589 e13f0cc8 b6630ca6; key with rodada_idx=1 is a0fafe17 88542cb1 23a33939 2a6c7605; final key (idx 0) equals the input; then ocupado=0.
- All-zero key → first delivered K10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e; all 11 keys match a forward reference model, reversed.
- Backpressure: pronto random (e.g. 1 cycle high, 3 low) → chave_rodada/rodada_idx stable while not accepted, no key skipped or duplicated, exactly 11 transfers.
- Reset asserted at expansion cycle 5 and again at rodada_idx=6 → next edge: all outputs 0, state OCIOSO; a fresh inicio then runs a clean full sequence.
- inicio pulsed during EXPANDE and ENTREGA with a different chave → ignored; outputs follow the originally latched key.
- Back-to-back: inicio asserted on the final-handshake cycle → ignored; inicio one cycle later → accepted, valido 10 cycles after it.

Source files
------------

// File: rtl/expande_chave_inversa_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon, S-box, key/word types, FSM states.
// Keys use a row-major byte layout: row r, column c lives at bits [32r+8c +: 8].
package pacote_aes;

  localparam int NUM_RODADAS = 10;

  typedef logic [127:0] chave_t;
  typedef logic [31:0]  palavra_t;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXPANDE = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Out-of-range rounds yield 0 so a stray index never reads past the table.
  function automatic logic [7:0] rcon(input logic [3:0] rodada);
    rcon = (rodada < 4'd10) ? RCON[rodada] : 8'h00;
  endfunction

  // Column c as a word whose byte r is row r.
  function automatic palavra_t coluna(input chave_t k, input int c);
    palavra_t w;
    for (int r = 0; r < 4; r++) w[8*r +: 8] = k[32*r + 8*c +: 8];
    return w;
  endfunction

  function automatic chave_t monta(input palavra_t c0, input palavra_t c1,
                                   input palavra_t c2, input palavra_t c3);
    chave_t k;
    for (int r = 0; r < 4; r++) begin
      k[32*r +:  8] = c0[8*r +: 8];
      k[32*r + 8 +: 8] = c1[8*r +: 8];
      k[32*r + 16 +: 8] = c2[8*r +: 8];
      k[32*r + 24 +: 8] = c3[8*r +: 8];
    end
    return k;
  endfunction

endpackage

// File: rtl/expande_chave_inversa_g.sv
// Key-schedule word function g: RotWord, SubWord, then Rcon[rodada] on row 0.
// Byte r of the word is row r of the key column.
module funcaoG
  import pacote_aes::*;
(
  input  logic [31:0] palavra,
  input  logic [3:0]  rodada,
  output logic [31:0] saida
);

  always_comb begin
    saida = '0;
    for (int r = 0; r < 4; r++)
      saida[8*r +: 8] = SBOX[palavra[8*((r + 1) % 4) +: 8]];
    saida[7:0] = saida[7:0] ^ rcon(rodada);
  end

endmodule

// File: rtl/expande_chave_inversa.sv
// Reverse-order AES-128 round-key streamer: expands forward to K10 in one working register,
// then emits K10..K0, recovering each earlier key with the inverse schedule step.
module expande_chave_inversa
  import pacote_aes::*;
#(
  parameter int NUM_RODADAS = pacote_aes::NUM_RODADAS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] chave,
  input  logic         inicio,
  output logic         ocupado,
  output logic [127:0] chave_rodada,
  output logic [3:0]   rodada_idx,
  output logic         valido,
  input  logic         pronto
);

  localparam int CW = $clog2(NUM_RODADAS + 1);

  estado_t        estado, prox;
  logic [CW-1:0]  contador, idx;
  chave_t         k, k_fwd, k_inv;
  palavra_t       g_palavra, g_saida;
  logic [3:0]     g_rodada;
  palavra_t       c0, c1, c2, c3;
  logic           ultimo_passo, entrega_ok;

  assign c0 = coluna(k, 0);
  assign c1 = coluna(k, 1);
  assign c2 = coluna(k, 2);
  assign c3 = coluna(k, 3);

  // The single g instance sees K(n-1).col3 going forward and the recovered old col3 going back.
  always_comb begin
    g_palavra = c3;
    g_rodada  = 4'(contador);
    if (estado == ENTREGA) begin
      g_palavra = c3 ^ c2;
      g_rodada  = 4'(idx - 1'b1);
    end
  end

  funcaoG u_g (
    .palavra (g_palavra),
    .rodada  (g_rodada),
    .saida   (g_saida)
  );

  always_comb begin
    palavra_t n0, n1, n2, n3;
    n0 = c0 ^ g_saida;
    n1 = n0 ^ c1;
    n2 = n1 ^ c2;
    n3 = n2 ^ c3;
    k_fwd = monta(n0, n1, n2, n3);
    k_inv = monta(c0 ^ g_saida, c1 ^ c0, c2 ^ c1, c3 ^ c2);
  end

  assign ultimo_passo = (contador == CW'(NUM_RODADAS - 1));
  assign entrega_ok   = (estado == ENTREGA) && pronto;

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (inicio) prox = EXPANDE;
      EXPANDE: if (ultimo_passo) prox = ENTREGA;
      ENTREGA: if (pronto && idx == '0) prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      k        <= '0;
      contador <= '0;
      idx      <= '0;
    end else begin
      estado <= prox;
      case (estado)
        OCIOSO: if (inicio) begin
          k        <= chave;
          contador <= '0;
        end
        EXPANDE: begin
          k        <= k_fwd;
          contador <= contador + 1'b1;
          if (ultimo_passo) idx <= CW'(NUM_RODADAS);
        end
        ENTREGA: if (entrega_ok && idx != '0) begin
          k   <= k_inv;
          idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ocupado      = (estado != OCIOSO);
  assign valido       = (estado == ENTREGA);
  assign chave_rodada = k;
  assign rodada_idx   = 4'(idx);

endmodule

// File: tb/tb_expande_chave_inversa.sv
// Bench for expande_chave_inversa: FIPS-197 vectors plus random keys against a word-oriented
// key-expansion model whose S-box is derived from GF(2^8) arithmetic.
module tb_expande_chave_inversa;

  logic         clock = 0;
  logic         reset = 1;
  logic [127:0] chave = '0;
  logic         inicio = 0;
  logic         pronto = 0;
  logic         ocupado, valido;
  logic [127:0] chave_rodada;
  logic [3:0]   rodada_idx;

  int total = 0;
  int bad = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] ref_k [0:10];
  logic [127:0] got [0:10];

  expande_chave_inversa dut (
    .clock        (clock),
    .reset        (reset),
    .chave        (chave),
    .inicio       (inicio),
    .ocupado      (ocupado),
    .chave_rodada (chave_rodada),
    .rodada_idx   (rodada_idx),
    .valido       (valido),
    .pronto       (pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 text order (four big-endian column words) to the row-major bus layout.
  function automatic logic [127:0] pack(input logic [127:0] fips);
    logic [127:0] k = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        k[32*r + 8*c +: 8] = fips[127 - 32*c - 8*r -: 8];
    return k;
  endfunction

  // Standard 44-word expansion, then each round key re-packed to the bus layout.
  task automatic modelo(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int c = 0; c < 4; c++)
      w[c] = {key[8*c +: 8], key[32 + 8*c +: 8], key[64 + 8*c +: 8], key[96 + 8*c +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n <= 10; n++)
      ref_k[n] = pack({w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]});
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_zero(input string tag);
    chk(tag, {ocupado, valido, rodada_idx, chave_rodada}, '0);
  endtask

  // Starts a run at a negedge and checks the 10-edge latency to valido.
  task automatic iniciar(input logic [127:0] key, input bit ruido);
    int lat = 0;
    modelo(key);
    chave = key; inicio = 1;
    @(negedge clock);
    inicio = 0; chave = rnd128();
    chk("busy_after_start", {ocupado, valido}, 2'b10);
    while (!valido && lat < 30) begin
      if (ruido) begin inicio = 1'($urandom); chave = rnd128(); end
      @(negedge clock);
      lat++;
    end
    inicio = 0;
    chk("latency", lat, 10);
  endtask

  // Consumes keys; modo 1 = random backpressure. Optional reset at rodada_idx==aborta.
  task automatic receber(input logic [127:0] key, input bit modo, input bit ruido,
                         input bit b2b, input int aborta);
    int exp_i = 10, xfers = 0, ciclos = 0;
    bit p;
    while (xfers < 11 && ciclos < 500) begin
      chk($sformatf("key_idx%0d", exp_i), {valido, rodada_idx, chave_rodada},
          {1'b1, 4'(exp_i), ref_k[exp_i]});
      got[exp_i] = chave_rodada;
      if (exp_i == aborta) begin
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk_zero("reset_mid_delivery");
        return;
      end
      p = modo ? ($urandom_range(0, 3) == 0) : 1'b1;
      pronto = p;
      inicio = 0;
      if (ruido) begin inicio = 1'($urandom); chave = rnd128(); end
      if (b2b && exp_i == 0 && p) begin inicio = 1; chave = rnd128(); end
      @(negedge clock);
      ciclos++;
      if (p) begin xfers++; exp_i--; end
    end
    pronto = 0; inicio = 0;
    chk("xfers", xfers, 11);
    chk("done_idle", {ocupado, valido, chave_rodada}, {2'b00, key});
  endtask

  initial begin
    logic [127:0] k;
    init_sbox();
    repeat (2) @(negedge clock);
    chk_zero("reset_state");
    reset = 0;
    @(negedge clock);
    chk_zero("idle_after_reset");

    // FIPS-197 Appendix A.1 key at full rate
    k = pack(128'h2b7e151628aed2a6abf7158809cf4f3c);
    iniciar(k, 0);
    receber(k, 0, 0, 0, -1);
    chk("fips_k10", got[10], pack(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("fips_k1", got[1], pack(128'ha0fafe1788542cb123a339392a6c7605));
    chk("fips_k0", got[0], k);

    // all-zero key with backpressure
    iniciar('0, 0);
    receber('0, 1, 0, 0, -1);
    chk("zero_k10", got[10], pack(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    // reset during expansion (5 edges after accept)
    chave = rnd128(); inicio = 1;
    @(negedge clock);
    inicio = 0;
    repeat (4) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk_zero("reset_mid_expand");

    // reset at rodada_idx 6, then a clean run
    k = rnd128();
    iniciar(k, 0);
    receber(k, 1, 0, 0, 6);
    @(negedge clock);
    chk_zero("idle_after_reset2");
    k = rnd128();
    iniciar(k, 0);
    receber(k, 0, 0, 0, -1);

    // inicio noise with other keys during EXPANDE and ENTREGA
    k = rnd128();
    iniciar(k, 1);
    receber(k, 1, 1, 0, -1);

    // back-to-back: start on final handshake ignored, start one cycle later accepted
    k = rnd128();
    iniciar(k, 0);
    receber(k, 0, 0, 1, -1);
    k = rnd128();
    iniciar(k, 0);
    receber(k, 1, 0, 0, -1);

    for (int i = 0; i < 4; i++) begin
      k = rnd128();
      iniciar(k, i[0]);
      receber(k, i[1], i[0], 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
